// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: funct3 encodings, result-source code,
// FSM state type and the alignment rule used by the access decode.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mem_state_t;

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3[1:0])
      2'b01:   return offset[0];
      2'b10:   return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Purely combinational load-data formatter: lane select by byte offset,
// then sign/zero extension according to funct3.
module load_formatter
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[8*i_offset +: 8];
  assign w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_W:    o_data = i_rdata;
      F3_BU:   o_data = {24'h0, w_byte};
      F3_HU:   o_data = {16'h0, w_half};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores over a req/ready handshake, stalls while an access
// is outstanding. Optional BUSY watchdog with BusErrM is enabled by MEM_ACCESS_TIMEOUT_EN.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter logic [31:0] RESET_VALUE_32 = 32'h0
`ifdef MEM_ACCESS_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        MemValidM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [31:0] InstrM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        HoldM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallMem,
`ifdef MEM_ACCESS_TIMEOUT_EN
  output logic        BusErrM,
`endif
  output logic        MisalignM
);

  mem_state_t  r_state;
  mem_state_t  w_next;
  logic [31:0] r_cap;
  logic [2:0]  w_funct3;
  logic [1:0]  w_offset;
  logic        w_is_load;
  logic        w_is_mem;
  logic        w_mis;
  logic        w_acc;
  logic        w_done;
  logic [31:0] w_fmt;
  logic [31:0] w_ld_data;
  logic        w_unused;

  assign w_funct3  = InstrM[14:12];
  assign w_offset  = ALUResultM[1:0];
  assign w_unused  = ^{InstrM[31:15], InstrM[11:0]};

  assign w_is_load = (ResultSrcM == RESULTSRC_LOAD);
  assign w_is_mem  = MemValidM & (MemWriteM | w_is_load);
  assign w_mis     = w_is_mem & is_misaligned(w_funct3, w_offset);
  assign w_acc     = w_is_mem & ~w_mis;
  assign MisalignM = w_mis;

  load_formatter u_load_formatter (
    .i_rdata  (dmem_rdata),
    .i_offset (w_offset),
    .i_funct3 (w_funct3),
    .o_data   (w_fmt)
  );

  // Stores never return data to MEM/WB.
  assign w_ld_data = (w_is_load & ~MemWriteM) ? w_fmt : 32'h0;

  assign dmem_we   = MemWriteM;
  assign dmem_addr = {ALUResultM[31:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = WriteDataM;
    if (MemWriteM) begin
      case (w_funct3[1:0])
        2'b00: begin
          dmem_be    = 4'b0001 << w_offset;
          dmem_wdata = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          dmem_be    = w_offset[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{WriteDataM[15:0]}};
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        w_timeout;
  assign w_timeout = (r_state == BUSY) & ~dmem_ready & (r_cnt == 16'(TIMEOUT_CYCLES));
`endif

  // NOTE: every combinational output gets a default before the case so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next   = r_state;
    dmem_req = 1'b0;
    StallMem = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      IDLE: begin
        dmem_req = w_acc;
        if (w_acc) begin
          if (dmem_ready) begin
            w_done = 1'b1;
            if (HoldM) w_next = DONE;
          end else begin
            StallMem = 1'b1;
            w_next   = BUSY;
          end
        end
      end
      BUSY: begin
        dmem_req = 1'b1;
        StallMem = ~dmem_ready;
        if (dmem_ready) begin
          w_done = 1'b1;
          w_next = HoldM ? DONE : IDLE;
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        else if (w_timeout) begin
          dmem_req = 1'b0;
          StallMem = 1'b0;
          w_next   = IDLE;
        end
`endif
      end
      DONE: begin
        if (!HoldM) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // An in-flight access is simply dropped while reset is held.
    if (!n_rst) begin
      dmem_req = 1'b0;
      StallMem = 1'b0;
    end
  end

  always_comb begin
    ReadDataM = 32'h0;
    if (r_state == DONE)  ReadDataM = r_cap;
    else if (w_done)      ReadDataM = w_ld_data;
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  assign BusErrM = w_timeout & n_rst;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_cap   <= RESET_VALUE_32;
    end else begin
      r_state <= w_next;
      if (w_done && HoldM) r_cap <= w_ld_data;
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  // r_cnt holds the number of BUSY cycles including the current one.
  always_ff @(posedge clk) begin
    if (!n_rst)                                 r_cnt <= '0;
    else if (r_state != BUSY && w_next == BUSY) r_cnt <= 16'd1;
    else if (r_state == BUSY)                   r_cnt <= r_cnt + 16'd1;
  end
`endif

endmodule
